id_ex_forward_stage: RTL and testbench

ID/EX pipeline register for the five-stage MIPS core, combined with load-use hazard detection and generation of the 2-bit forwarding selects. These selects drive the two 32-bit 3-to-1 operand muxes at the ALU inputs. The block captures decoded operands and control from ID each cycle, inserts bubbles on load-use hazards and branch flushes, and tells IF/ID when to hold.

---
 rtl/id_ex_forward_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_forward_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_forward_stage.sv
// id_ex_forward_stage: ID/EX pipeline register for the five-stage MIPS core.
// Also detects load-use hazards (stalling PC and IF/ID), turns flushes and
// stalls into bubbles, and produces the 2-bit ALU operand forwarding selects.
// Optional feature: define ID_EX_STALL_CNT_EN to add a saturating 16-bit
// stall_count output that counts stalled cycles.
module id_ex_forward_stage #(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_imm,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic              memwb_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic [4:0]        memwb_rd,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
`ifdef ID_EX_STALL_CNT_EN
    output logic [15:0]       stall_count,
`endif
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    // Select codes for the ALU operand muxes; 2'b11 is never produced.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    logic load_dep;

    // A load in EX whose destination is read by the instruction in ID must
    // hold ID for one cycle; $0 never creates a dependency, and a flush
    // kills the consumer so there is nothing left to hold.
    assign load_dep = (ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt));
    assign stall    = ex_valid & ex_mem_read & id_valid & (ex_rd != 5'd0)
                      & load_dep & ~flush;

    // Pipeline register: synchronous clear, bubble on flush/stall, else load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
        end else begin
            // Operand fields load unconditionally; in a bubble they are
            // don't-care because ex_valid gates every downstream use.
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            if (flush | stall) begin
                ex_valid     <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_ctrl      <= '0;
            end else begin
                ex_valid     <= id_valid;
                ex_mem_read  <= id_mem_read;
                ex_reg_write <= id_reg_write;
                ex_ctrl      <= id_ctrl;
            end
        end
    end

    // Forwarding selects: EX/MEM (younger) beats MEM/WB; $0 never forwards.
    always_comb begin
        // NOTE: defaults first so every path assigns both selects and no
        // latch is inferred.
        forward_a = FWD_REG;
        forward_b = FWD_REG;
        if (ex_valid) begin
            if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs))
                forward_a = FWD_EXMEM;
            else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs))
                forward_a = FWD_MEMWB;

            if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rt))
                forward_b = FWD_EXMEM;
            else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rt))
                forward_b = FWD_MEMWB;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    // Saturating count of stalled cycles; flush-only cycles do not count
    // because stall is already suppressed by flush.
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Self-checking bench for id_ex_forward_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_id_ex_forward_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rt, id_mem_read, id_reg_write, flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [7:0]  id_ctrl;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        stall, ex_valid, ex_mem_read, ex_reg_write;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [7:0]  ex_ctrl;
    logic [1:0]  forward_a, forward_b;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model of what the EX stage should hold; m_care is cleared after a
    // bubble, when the operand fields are don't-care.
    logic        m_valid, m_mem_read, m_reg_write, m_care;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rs_data, m_rt_data, m_imm;
    logic [7:0]  m_ctrl;
    int unsigned m_cnt;

    id_ex_forward_stage #(.CTRL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_ctrl(id_ctrl),
        .flush(flush), .exmem_reg_write(exmem_reg_write),
        .memwb_reg_write(memwb_reg_write), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .stall(stall), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_ctrl(ex_ctrl),
`ifdef ID_EX_STALL_CNT_EN
        .stall_count(stall_count),
`endif
        .forward_a(forward_a), .forward_b(forward_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // A load sitting in EX blocks the ID instruction if ID reads its result.
    function automatic logic exp_stall();
        logic reads_it;
        reads_it = (m_rd == id_rs) || (id_uses_rt && (m_rd == id_rt));
        return m_valid && m_mem_read && id_valid && (m_rd != 5'd0) && reads_it && !flush;
    endfunction

    // Producers listed youngest first; the first one writing src supplies it.
    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        logic       wr [2];
        logic [4:0] dst [2];
        logic [1:0] code [2];
        wr[0] = exmem_reg_write; dst[0] = exmem_rd; code[0] = 2'b10;
        wr[1] = memwb_reg_write; dst[1] = memwb_rd; code[1] = 2'b01;
        if (!m_valid || src == 5'd0) return 2'b00;
        for (int i = 0; i < 2; i++)
            if (wr[i] && dst[i] == src) return code[i];
        return 2'b00;
    endfunction

    // Compare every output against the model, away from the rising edge.
    task automatic sample();
        @(negedge clk);
        check("stall", 32'(stall), 32'(exp_stall()));
        check("forward_a", 32'(forward_a), 32'(exp_fwd(m_rs)));
        check("forward_b", 32'(forward_b), 32'(exp_fwd(m_rt)));
        check("ex_valid", 32'(ex_valid), 32'(m_valid));
        check("ex_mem_read", 32'(ex_mem_read), 32'(m_mem_read));
        check("ex_reg_write", 32'(ex_reg_write), 32'(m_reg_write));
        check("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        if (m_care) begin
            check("ex_rs", 32'(ex_rs), 32'(m_rs));
            check("ex_rt", 32'(ex_rt), 32'(m_rt));
            check("ex_rd", 32'(ex_rd), 32'(m_rd));
            check("ex_rs_data", ex_rs_data, m_rs_data);
            check("ex_rt_data", ex_rt_data, m_rt_data);
            check("ex_imm", ex_imm, m_imm);
        end
`ifdef ID_EX_STALL_CNT_EN
        check("stall_count", 32'(stall_count), m_cnt);
`endif
    endtask

    // Apply the next rising edge to the model, then move to just past it.
    task automatic advance();
        logic bubble;
        bubble = flush || exp_stall();
        if (!rst_n) begin
            m_cnt = 0;
        end else if (exp_stall() && m_cnt != 32'hFFFF) begin
            m_cnt = m_cnt + 1;
        end
        if (!rst_n) begin
            {m_valid, m_mem_read, m_reg_write} = 3'b000;
            {m_rs, m_rt, m_rd} = '0;
            {m_rs_data, m_rt_data, m_imm} = '0;
            m_ctrl = '0;
            m_care = 1'b1;
        end else begin
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
            if (bubble) begin
                {m_valid, m_mem_read, m_reg_write} = 3'b000;
                m_ctrl = '0;
                m_care = 1'b0;
            end else begin
                m_valid = id_valid; m_mem_read = id_mem_read;
                m_reg_write = id_reg_write; m_ctrl = id_ctrl;
                m_care = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic urt, input logic ld,
                             input logic wr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
        id_mem_read = ld; id_reg_write = wr;
        id_rs_data = $urandom(); id_rt_data = $urandom(); id_imm = $urandom();
        id_ctrl = 8'($urandom_range(1, 255));
    endtask

    task automatic rand_inputs();
        set_instr(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)));
        flush           = ($urandom_range(0, 9) == 0);
        exmem_reg_write = 1'($urandom_range(0, 1));
        memwb_reg_write = 1'($urandom_range(0, 1));
        exmem_rd        = 5'($urandom_range(0, 7));
        memwb_rd        = 5'($urandom_range(0, 7));
    endtask

    int unsigned cnt_before;

    initial begin
        {m_valid, m_mem_read, m_reg_write, m_care} = 4'b0001;
        {m_rs, m_rt, m_rd} = '0;
        {m_rs_data, m_rt_data, m_imm} = '0;
        m_ctrl = '0;
        m_cnt = 0;

        // Reset held for two cycles with random ID traffic.
        rst_n = 1'b0;
        rand_inputs();
        @(posedge clk);
        #1;
        rand_inputs();
        sample();
        advance();
        rand_inputs();
        sample();
        check("rst_forward_a", 32'(forward_a), 32'd0);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        advance();

        // EX/MEM forwarding beats MEM/WB on rs; MEM/WB alone feeds rt.
        rst_n = 1'b1;
        flush = 1'b0;
        {exmem_reg_write, memwb_reg_write} = 2'b00;
        set_instr(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1);
        advance();
        exmem_reg_write = 1'b1; exmem_rd = 5'd5;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5;
        set_instr(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        sample();
        check("exmem_fwd_a", 32'(forward_a), 32'd2);
        check("exmem_fwd_b", 32'(forward_b), 32'd0);
        memwb_rd = 5'd6;
        #1;
        check("memwb_fwd_b", 32'(forward_b), 32'd1);
        check("memwb_fwd_b_model", 32'(forward_b), 32'(exp_fwd(m_rt)));
        set_instr(1'b1, 5'd0, 5'd6, 5'd9, 1'b1, 1'b0, 1'b1);
        advance();

        // $0 is never forwarded.
        exmem_reg_write = 1'b1; exmem_rd = 5'd0;
        memwb_reg_write = 1'b0;
        sample();
        check("zero_guard_fwd_a", 32'(forward_a), 32'd0);

        // Load-use on rs: one stall, one bubble, then forward from MEM/WB.
        exmem_reg_write = 1'b0;
        set_instr(1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b1);
        advance();
        set_instr(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b1);
        sample();
        check("lu_stall", 32'(stall), 32'd1);
        cnt_before = m_cnt;
        advance();
        sample();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_stall_drop", 32'(stall), 32'd0);
        check("lu_cnt_step", m_cnt, cnt_before + 1);
        advance();
        memwb_reg_write = 1'b1; memwb_rd = 5'd8;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        sample();
        check("lu_consumer_valid", 32'(ex_valid), 32'd1);
        check("lu_consumer_fwd_a", 32'(forward_a), 32'd1);
        memwb_reg_write = 1'b0;

        // rt matches the load but is not read: no stall.
        set_instr(1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b1);
        advance();
        set_instr(1'b1, 5'd3, 5'd8, 5'd11, 1'b0, 1'b0, 1'b1);
        sample();
        check("rt_unused_stall", 32'(stall), 32'd0);

        // Flush and load-use together: flush wins, no stall counted.
        set_instr(1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b1);
        advance();
        set_instr(1'b1, 5'd8, 5'd4, 5'd12, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        sample();
        check("flush_stall", 32'(stall), 32'd0);
        cnt_before = m_cnt;
        advance();
        flush = 1'b0;
        sample();
        check("flush_ex_valid", 32'(ex_valid), 32'd0);
        check("flush_ex_ctrl", 32'(ex_ctrl), 32'd0);
        check("flush_cnt_hold", m_cnt, cnt_before);
        advance();

        // Randomized traffic, including occasional mid-run resets.
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            rand_inputs();
            sample();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
